// File: rtl/maxnet_param.sv
// MAXNET winner-take-all competition: N neurons mutually inhibit until exactly one stays nonzero,
// all become zero, or the iteration limit is reached.
module maxnet_param #(
    parameter int unsigned N         = 4,
    parameter int unsigned W         = 8,
    parameter int unsigned EPS_SHIFT = 2,
    parameter int unsigned MAX_ITER  = 15
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [N*W-1:0]                in_data,
    output logic                          busy,
    output logic                          done,
    output logic [W-1:0]                  result,
    output logic [$clog2(N)-1:0]          winner_idx,
    output logic                          no_winner,
    output logic [$clog2(MAX_ITER+1)-1:0] iter_count
);

    localparam int unsigned IDX_W = $clog2(N);
    localparam int unsigned IT_W  = $clog2(MAX_ITER + 1);
    localparam int unsigned SUM_W = W + $clog2(N);
    localparam int unsigned NZ_W  = $clog2(N + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [W-1:0]       act_q [N];
    logic [W-1:0]       act_d [N];
    logic [IT_W-1:0]    iter_q, iter_d;
    logic [W-1:0]       result_q, result_d;
    logic [IDX_W-1:0]   widx_q, widx_d;
    logic               nw_q, nw_d;
    logic               done_q, done_d;
    logic               busy_q, busy_d;

    logic [SUM_W-1:0]   sum_c;
    logic [NZ_W-1:0]    nz_c;
    logic [IDX_W-1:0]   nz_idx_c;
    logic [SUM_W-1:0]   inhib_c [N];
    logic [W-1:0]       upd_c   [N];

    // Total activation, nonzero count and the (last) nonzero index, plus the next activation of each neuron
    always_comb begin
        sum_c    = '0;
        nz_c     = '0;
        nz_idx_c = '0;
        for (int i = 0; i < N; i++) begin
            sum_c = sum_c + SUM_W'(act_q[i]);
            if (act_q[i] != '0) begin
                nz_c     = nz_c + NZ_W'(1);
                nz_idx_c = IDX_W'(i);
            end
        end
        for (int i = 0; i < N; i++) begin
            // Inhibition from all other neurons: (T - a_i) never underflows since T includes a_i
            inhib_c[i] = (sum_c - SUM_W'(act_q[i])) >> EPS_SHIFT;
            if (inhib_c[i] >= SUM_W'(act_q[i])) begin
                upd_c[i] = '0;
            end else begin
                upd_c[i] = W'(SUM_W'(act_q[i]) - inhib_c[i]);
            end
        end
    end

    // Next-state and output decisions
    always_comb begin
        state_d  = state_q;
        act_d    = act_q;
        iter_d   = iter_q;
        result_d = result_q;
        widx_d   = widx_q;
        nw_d     = nw_q;
        done_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                    iter_d  = '0;
                    for (int i = 0; i < N; i++) begin
                        act_d[i] = in_data[i*W +: W];
                    end
                end
            end
            S_RUN: begin
                if (nz_c == NZ_W'(1)) begin
                    state_d  = S_DONE;
                    done_d   = 1'b1;
                    widx_d   = nz_idx_c;
                    result_d = act_q[nz_idx_c];
                    nw_d     = 1'b0;
                end else if ((nz_c == '0) || (iter_q == IT_W'(MAX_ITER))) begin
                    state_d  = S_DONE;
                    done_d   = 1'b1;
                    widx_d   = '0;
                    result_d = '0;
                    nw_d     = 1'b1;
                end else begin
                    act_d  = upd_c;
                    iter_d = iter_q + IT_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            iter_q   <= '0;
            result_q <= '0;
            widx_q   <= '0;
            nw_q     <= 1'b0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
            for (int i = 0; i < N; i++) begin
                act_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            iter_q   <= iter_d;
            result_q <= result_d;
            widx_q   <= widx_d;
            nw_q     <= nw_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
            for (int i = 0; i < N; i++) begin
                act_q[i] <= act_d[i];
            end
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign result     = result_q;
    assign winner_idx = widx_q;
    assign no_winner  = nw_q;
    assign iter_count = iter_q;

endmodule

// File: tb/tb_maxnet_param.sv
// Self-checking bench for maxnet_param: directed cases, randomized competitions against an
// integer reference model, mid-run reset, start-while-busy and output hold.
module tb_maxnet_param;

    localparam int N   = 4;
    localparam int W   = 8;
    localparam int EPS = 2;
    localparam int MI  = 15;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic [N*W-1:0] in_data;
    logic           busy;
    logic           done;
    logic [W-1:0]   result;
    logic [1:0]     winner_idx;
    logic           no_winner;
    logic [3:0]     iter_count;

    int cmp_cnt = 0;
    int err_cnt = 0;

    maxnet_param #(.N(N), .W(W), .EPS_SHIFT(EPS), .MAX_ITER(MI)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .in_data    (in_data),
        .busy       (busy),
        .done       (done),
        .result     (result),
        .winner_idx (winner_idx),
        .no_winner  (no_winner),
        .iter_count (iter_count)
    );

    always #5 clk = ~clk;

    // Competition rules in plain signed arithmetic
    function automatic void ref_model(input int a_in[N], output int w, output int r,
                                      output int nw, output int it);
        int a[N];
        int b[N];
        int t;
        int nz;
        int idx;
        a  = a_in;
        it = 0;
        w  = 0;
        r  = 0;
        nw = 1;
        for (int s = 0; s <= MI + 1; s++) begin
            nz  = 0;
            idx = 0;
            t   = 0;
            for (int i = 0; i < N; i++) begin
                t += a[i];
                if (a[i] != 0) begin
                    nz++;
                    idx = i;
                end
            end
            if (nz == 1) begin
                w = idx; r = a[idx]; nw = 0;
                return;
            end
            if (nz == 0 || it == MI) begin
                w = 0; r = 0; nw = 1;
                return;
            end
            for (int i = 0; i < N; i++) begin
                b[i] = a[i] - ((t - a[i]) >> EPS);
                if (b[i] < 0) b[i] = 0;
            end
            a = b;
            it++;
        end
    endfunction

    function automatic logic [N*W-1:0] pack(input int a[N]);
        logic [N*W-1:0] v;
        for (int i = 0; i < N; i++) v[i*W +: W] = W'(a[i]);
        return v;
    endfunction

    // Pulse start with a[], then return the spec-style latency: done sampled at edge lat after start
    // (seen #1 after edge j means it is high when edge j+1 samples it); -1 on timeout.
    task automatic run_comp(input int a[N], output int lat);
        in_data = pack(a);
        start   = 1'b1;
        @(posedge clk); #1;
        start   = 1'b0;
        in_data = $urandom();
        lat     = -1;
        for (int j = 1; j <= MI + 10; j++) begin
            @(posedge clk); #1;
            if (done) begin
                lat = j + 1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; in_data = 32'h0A141E28;
        repeat (2) @(posedge clk);
        #1;
        start = 1'b0;
        rst   = 1'b0;
        cmp_cnt++;
        if ({busy, done, result, winner_idx, no_winner, iter_count} !== 17'd0) begin
            err_cnt++;
            $display("FAIL reset_state: got busy=%b done=%b result=%0d widx=%0d nw=%b iter=%0d, want all 0",
                     busy, done, result, winner_idx, no_winner, iter_count);
        end
        @(posedge clk); #1;
        cmp_cnt++;
        if (busy !== 1'b0) begin
            err_cnt++;
            $display("FAIL reset_start_priority: busy=%b want 0", busy);
        end
    endtask

    task automatic test_directed();
        int vec[4][N] = '{'{10, 20, 30, 40}, '{0, 0, 50, 0}, '{0, 0, 0, 0}, '{8, 8, 0, 0}};
        // winner, result, no_winner, iter_count, done latency
        int exp_v[4][5] = '{'{3, 21, 0, 4, 6}, '{2, 50, 0, 0, 2}, '{0, 0, 1, 0, 2}, '{0, 0, 1, 15, 17}};
        int lat;
        for (int t = 0; t < 4; t++) begin
            run_comp(vec[t], lat);
            cmp_cnt++;
            if (lat !== exp_v[t][4] || int'(winner_idx) !== exp_v[t][0] || int'(result) !== exp_v[t][1] ||
                int'(no_winner) !== exp_v[t][2] || int'(iter_count) !== exp_v[t][3]) begin
                err_cnt++;
                $display("FAIL directed_%0d: got lat=%0d widx=%0d res=%0d nw=%0d iter=%0d, want %0d/%0d/%0d/%0d/%0d",
                         t, lat, winner_idx, result, no_winner, iter_count,
                         exp_v[t][4], exp_v[t][0], exp_v[t][1], exp_v[t][2], exp_v[t][3]);
            end
            @(posedge clk); #1;
            cmp_cnt++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                err_cnt++;
                $display("FAIL directed_%0d_pulse: done=%b busy=%b one cycle later, want 0/0", t, done, busy);
            end
        end
    endtask

    task automatic test_random();
        int a[N];
        int w, r, nw, it, lat;
        for (int t = 0; t < 40; t++) begin
            for (int i = 0; i < N; i++) begin
                a[i] = ($urandom_range(3, 0) == 0) ? 0 : int'($urandom_range(255, 1));
            end
            if (t % 8 == 7) begin
                a[0] = int'($urandom_range(255, 1));
                a[1] = a[0];
            end
            ref_model(a, w, r, nw, it);
            run_comp(a, lat);
            cmp_cnt++;
            if (lat !== it + 2 || int'(winner_idx) !== w || int'(result) !== r ||
                int'(no_winner) !== nw || int'(iter_count) !== it) begin
                err_cnt++;
                $display("FAIL random_%0d {%0d,%0d,%0d,%0d}: got lat=%0d widx=%0d res=%0d nw=%0d iter=%0d, want %0d/%0d/%0d/%0d/%0d",
                         t, a[0], a[1], a[2], a[3], lat, winner_idx, result, no_winner, iter_count,
                         it + 2, w, r, nw, it);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_mid_run();
        int a[N] = '{10, 20, 30, 40};
        int b[N] = '{0, 0, 50, 0};
        int lat;
        bit saw_done;
        in_data = pack(a);
        start   = 1'b1;
        @(posedge clk); #1;
        start   = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        cmp_cnt++;
        if ({busy, done, result, winner_idx, no_winner, iter_count} !== 17'd0) begin
            err_cnt++;
            $display("FAIL midrun_reset_state: got busy=%b done=%b result=%0d widx=%0d nw=%b iter=%0d, want all 0",
                     busy, done, result, winner_idx, no_winner, iter_count);
        end
        saw_done = 1'b0;
        repeat (20) begin
            @(posedge clk); #1;
            if (done || busy) saw_done = 1'b1;
        end
        cmp_cnt++;
        if (saw_done !== 1'b0) begin
            err_cnt++;
            $display("FAIL midrun_reset_abort: got activity=%b after reset, want 0", saw_done);
        end
        run_comp(b, lat);
        cmp_cnt++;
        if (lat !== 2 || winner_idx !== 2'd2 || result !== 8'd50 || no_winner !== 1'b0) begin
            err_cnt++;
            $display("FAIL midrun_restart: got lat=%0d widx=%0d res=%0d nw=%0d, want 2/2/50/0",
                     lat, winner_idx, result, no_winner);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_busy_start_and_hold();
        int a[N] = '{10, 20, 30, 40};
        int b[N] = '{0, 0, 50, 0};
        int lat;
        in_data = pack(a);
        start   = 1'b1;
        @(posedge clk); #1;
        start   = 1'b0;
        cmp_cnt++;
        if (busy !== 1'b1) begin
            err_cnt++;
            $display("FAIL busy_after_start: busy=%b want 1", busy);
        end
        @(posedge clk); #1;
        in_data = pack(b);
        start   = 1'b1;
        @(posedge clk); #1;
        start   = 1'b0;
        lat = -1;
        for (int j = 3; j <= MI + 10; j++) begin
            @(posedge clk); #1;
            if (done) begin
                lat = j + 1;
                break;
            end
        end
        cmp_cnt++;
        if (lat !== 6 || winner_idx !== 2'd3 || result !== 8'd21 || iter_count !== 4'd4 || no_winner !== 1'b0) begin
            err_cnt++;
            $display("FAIL busy_start_ignored: got lat=%0d widx=%0d res=%0d iter=%0d nw=%0d, want 6/3/21/4/0",
                     lat, winner_idx, result, iter_count, no_winner);
        end
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            in_data = $urandom();
            cmp_cnt++;
            if (busy !== 1'b0 || done !== 1'b0 || winner_idx !== 2'd3 || result !== 8'd21 ||
                iter_count !== 4'd4 || no_winner !== 1'b0) begin
                err_cnt++;
                $display("FAIL hold_%0d: got busy=%b done=%b widx=%0d res=%0d iter=%0d nw=%0d, want 0/0/3/21/4/0",
                         c, busy, done, winner_idx, result, iter_count, no_winner);
            end
        end
    endtask

    initial begin
        rst     = 1'b1;
        start   = 1'b0;
        in_data = '0;
        test_reset();
        test_directed();
        test_random();
        test_reset_mid_run();
        test_busy_start_and_hold();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
